// File: rtl/fft_reorder_pkg.sv
// Shared constants, bit-reversal helper and read-FSM encoding for the FFT output reorder buffer.
package fft_reorder_pkg;

   localparam int N     = 128;
   localparam int LANES = 4;
   localparam int LOG2N = 7;
   localparam int BEATS = N / LANES;
   localparam int CNTW  = $clog2(BEATS);
   localparam int LANEW = $clog2(LANES);

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rdState_t;

   // Reverses the low nbits of w; higher bits of the result stay zero.
   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] w, input int nbits);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         if (i < nbits) r[i] = w[nbits-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_buf_bank.sv
// One N-entry reorder bank: LANES synchronous write ports, LANES asynchronous read ports.
module reorder_bank
   import fft_reorder_pkg::*;
#(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic [LANES-1:0] wrEn,
   input  logic [LOG2N-1:0] wrAddr [LANES],
   input  logic [WIDTH-1:0] wrData [LANES],
   input  logic [LOG2N-1:0] rdAddr [LANES],
   output logic [WIDTH-1:0] rdData [LANES]
);

   logic [WIDTH-1:0] mem [N];

   // NOTE: storage arrays carry no reset; every entry is rewritten before it is ever read.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (wrEn[l]) mem[wrAddr[l]] <= wrData[l];
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rdData[l] = mem[rdAddr[l]];
      end
   end

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: bit-reversed 4-lane FFT output in, natural-order bins out.
// Optional start-of-frame marker out_sof enabled by defining FFT_REORDER_SOF_EN.
module fft_reorder_buf
   import fft_reorder_pkg::*;
#(
   parameter int NBITS_out = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [NBITS_out*2-1:0] fftIn0_up,
   input  logic [NBITS_out*2-1:0] fftIn0_down,
   input  logic [NBITS_out*2-1:0] fftIn1_up,
   input  logic [NBITS_out*2-1:0] fftIn1_down,
   output logic                   out_valid,
   output logic [NBITS_out*2-1:0] out0,
   output logic [NBITS_out*2-1:0] out1,
   output logic [NBITS_out*2-1:0] out2,
   output logic [NBITS_out*2-1:0] out3
`ifdef FFT_REORDER_SOF_EN
   ,
   output logic                   out_sof
`endif
);

   localparam int W = NBITS_out * 2;

   logic [CNTW-1:0]  wrCnt;
   logic             wrBank;
   logic             frameDone;
   logic [LANES-1:0] wrEn0, wrEn1;
   logic [W-1:0]     laneIn  [LANES];
   logic [LOG2N-1:0] wrAddr  [LANES];
   logic [LOG2N-1:0] rdAddr  [LANES];
   logic [W-1:0]     rdData0 [LANES];
   logic [W-1:0]     rdData1 [LANES];
   logic [W-1:0]     rdSel   [LANES];

   rdState_t        state, stateNext;
   logic [CNTW-1:0] rdCnt, rdCntNext;
   logic            rdBank, rdBankNext;
   logic            doRead;

   assign frameDone = in_valid && (wrCnt == CNTW'(BEATS - 1));
   assign wrEn0     = {LANES{in_valid && rst && !wrBank}};
   assign wrEn1     = {LANES{in_valid && rst &&  wrBank}};

   always_comb begin
      laneIn[0] = fftIn0_up;
      laneIn[1] = fftIn0_down;
      laneIn[2] = fftIn1_up;
      laneIn[3] = fftIn1_down;
      for (int l = 0; l < LANES; l++) begin
         wrAddr[l] = bitrev({wrCnt, LANEW'(l)}, LOG2N);
         rdAddr[l] = {rdCnt, LANEW'(l)};
         rdSel[l]  = rdBank ? rdData1[l] : rdData0[l];
      end
   end

   reorder_bank #(.WIDTH(W)) bank0 (
      .clk    (clk),
      .wrEn   (wrEn0),
      .wrAddr (wrAddr),
      .wrData (laneIn),
      .rdAddr (rdAddr),
      .rdData (rdData0)
   );

   reorder_bank #(.WIDTH(W)) bank1 (
      .clk    (clk),
      .wrEn   (wrEn1),
      .wrAddr (wrAddr),
      .wrData (laneIn),
      .rdAddr (rdAddr),
      .rdData (rdData1)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wrCnt  <= '0;
         wrBank <= 1'b0;
      end else if (in_valid) begin
         wrCnt <= wrCnt + CNTW'(1);
         if (frameDone) wrBank <= ~wrBank;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      stateNext  = state;
      rdCntNext  = rdCnt;
      rdBankNext = rdBank;
      doRead     = (state == READ);
      if (doRead) begin
         rdCntNext = rdCnt + CNTW'(1);
         if (rdCnt == CNTW'(BEATS - 1)) stateNext = IDLE;
      end
      // A completion on the last read beat chains straight into the next frame.
      if (frameDone) begin
         stateNext  = READ;
         rdCntNext  = '0;
         rdBankNext = wrBank;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         rdCnt     <= '0;
         rdBank    <= 1'b0;
         out_valid <= 1'b0;
         out0      <= '0;
         out1      <= '0;
         out2      <= '0;
         out3      <= '0;
      end else begin
         state     <= stateNext;
         rdCnt     <= rdCntNext;
         rdBank    <= rdBankNext;
         out_valid <= doRead;
         if (doRead) begin
            out0 <= rdSel[0];
            out1 <= rdSel[1];
            out2 <= rdSel[2];
            out3 <= rdSel[3];
         end
      end
   end

`ifdef FFT_REORDER_SOF_EN
   always_ff @(posedge clk) begin
      if (!rst) out_sof <= 1'b0;
      else      out_sof <= doRead && (rdCnt == '0);
   end
`endif

endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Output reorder buffer directly downstream of the final FFT stage (stage-7 butterflies plus Sat3 saturation to 10-bit re/im).
- Consumes the four parallel 20-bit complex lanes, which arrive in bit-reversed bin order.
- Emits each 128-point frame in natural bin order, four bins per cycle.
- Uses a ping-pong pair of 128-entry banks so that continuous frames stream without stalls.

Parameters:
- NBITS_out, 10, bits per real/imag component; a lane word is NBITS_out*2 bits, {re, im}.
- N, 128, FFT length (power of 2).
- LANES, 4, parallel lanes; BEATS = N/LANES = 32 beats per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- in_valid  in  1  lane inputs carry a valid beat this cycle.
- fftIn0_up  in  NBITS_out*2  lane 0.
- fftIn0_down  in  NBITS_out*2  lane 1.
- fftIn1_up  in  NBITS_out*2  lane 2.
- fftIn1_down  in  NBITS_out*2  lane 3.
- out_valid  out  1  output lanes valid.
- out0  out  NBITS_out*2  natural-order bin 4k+0.
- out1  out  NBITS_out*2  bin 4k+1.
- out2  out  NBITS_out*2  bin 4k+2.
- out3  out  NBITS_out*2  bin 4k+3.

Behaviour:
- Reset (rst=0 at a clk edge):
  - wr_cnt=0, wr_bank=0, read FSM=IDLE, rd_cnt=0.
  - out_valid=0, out0..out3=0.
  - Bank contents are not cleared.
- Write side:
  - Each clk edge with in_valid=1 is one beat c = wr_cnt (0..31).
  - Lane l (order 0_up, 0_down, 1_up, 1_down = 0..3) has arrival index w = 4c+l.
  - It is stored at bank[wr_bank] address bitrev_log2N(w).
  - wr_cnt increments per valid beat; gaps (in_valid=0) are allowed and hold wr_cnt.
- Frame complete:
  - Completion is the edge capturing beat 31.
  - At that edge: wr_cnt wraps to 0, wr_bank toggles, and a read of the just-filled bank is launched (rd_bank = old wr_bank).
- Read FSM:
  - IDLE -> READ on frame complete.
  - In READ, at each of the 32 edges following the completion edge T (T+1..T+32):
    - outj <= bank[rd_bank][4*rd_cnt + j], for j = 0..3.
    - out_valid <= 1.
    - rd_cnt increments.
  - At the beat with rd_cnt=31: if a new frame completes on that same edge, the FSM stays in READ with rd_cnt=0 and the new rd_bank (back-to-back frames give unbroken out_valid). Otherwise READ -> IDLE.
  - In IDLE: out_valid <= 0; outputs hold their last value.
- Latency: first output beat appears 1 edge after the completion edge.
- Overrun: cannot occur. The write rate is at most 1 beat/cycle, so the earliest next completion is T+32, which coincides with the last read. Writes into the other bank never collide with the active read bank.
- Simultaneous write and read: allowed, because they always target opposite banks.
- Reset mid-frame or mid-read: the partial input frame is discarded and any read in progress is aborted (out_valid=0 on the next cycle).
- Data passes through unmodified, with no arithmetic; widths are preserved.

Optional Feature:
- Macro: FFT_REORDER_SOF_EN.
- When defined:
  - Adds output port out_sof (1 bit).
  - out_sof is 1 exactly on the first output beat (rd_cnt=0) of each frame and 0 otherwise; reset value 0.
- When undefined: the port is absent and there is no added logic.

Decomposition:
- Package fft_reorder_pkg holds:
  - constants N, LANES, LOG2N=7, BEATS=32;
  - the function bitrev(w, LOG2N);
  - the read-FSM state encoding IDLE/READ.
- Sub-module reorder_bank: one N-entry bank of NBITS_out*2-bit words with LANES write ports (write enable, address, data) and LANES asynchronous read ports. It is instantiated twice, for bank 0 and bank 1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid toggling -> out_valid=0 and out0..3=0 throughout.
- Single frame with lane data re=w, im=~w[9:0], 32 continuous beats:
  - beat 0 gives re 0, 64, 32, 96;
  - beat 1 gives re 16, 80, 48, 112;
  - out_valid is high for exactly 32 cycles, starting 1 edge after beat 31.
- Back-to-back frames A, B over 64 continuous cycles -> out_valid is unbroken for 64 cycles; A appears in natural order, then B, with no corruption of A by B's writes.
- Gapped input: in_valid=1 on every other cycle for one frame -> output is identical to the single-frame case, starting 1 edge after the 32nd valid beat.
- Reset mid-operation:
  - rst=0 after 10 input beats -> no output;
  - a following full frame is reordered correctly, so wr_cnt restarted at 0;
  - rst=0 during output beat 5 -> out_valid drops the next cycle.
- FFT_REORDER_SOF_EN defined, back-to-back frames -> out_sof pulses once per frame, coincident with bins 0..3.
